// File: rtl/bp_be_accel_ws_xor_core.sv
// Weight-stationary XOR compute core: two stationary weights, XOR pipeline,
// result block buffer and a beat streamer for the BE accelerator pipe.
//
// Ports:
//   clk_i, reset_i  clock, async active-high reset
//   op_i, data_i    op (ACLD0/ACLD1/WTLD0/WTLD1) and operand block, valid with v_i
//   v_i             op+data valid, always consumed
//   data_o, v_o     result beat and its valid
//   yumi_i          downstream takes the current beat
//   ready_o         credit available (occupancy < els_p)
//   overflow_o      sticky flag: an ACLD was dropped for lack of credit
module bp_be_accel_ws_xor_core #(
    parameter int block_width_p = 512,
    parameter int fill_width_p  = 128,
    parameter int els_p         = 2,
    parameter int stages_p      = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [1:0]               op_i,
    input  logic [block_width_p-1:0] data_i,
    input  logic                     v_i,
    output logic [fill_width_p-1:0]  data_o,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic                     ready_o,
    output logic                     overflow_o
);

    localparam int beats_lp  = block_width_p / fill_width_p;
    localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp  = $clog2(els_p + 1);

    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_lp - 1);
    localparam logic [ptr_w_lp-1:0]  last_ptr_lp  = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0]  els_lp       = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0]  one_lp       = cnt_w_lp'(1);

    typedef enum logic {
        e_empty,
        e_stream
    } state_e;

    // ------------------------------------------------------------------
    // Weights and issue
    // ------------------------------------------------------------------
    logic [block_width_p-1:0] w0;
    logic [block_width_p-1:0] w1;
    logic [block_width_p-1:0] xor_res;
    logic                     is_acld;
    logic                     issue;
    logic                     drop;
    logic [cnt_w_lp-1:0]      occ;

    assign ready_o = (occ < els_lp);
    assign is_acld = v_i & ~op_i[1];
    assign issue   = is_acld & ready_o;
    assign drop    = is_acld & ~ready_o;

    // Weight mux reads the registered value, so a WTLD is seen one cycle later
    assign xor_res = data_i ^ (op_i[0] ? w1 : w0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w0         <= '0;
            w1         <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (v_i && op_i[1]) begin
                if (op_i[0]) begin
                    w1 <= data_i;
                end else begin
                    w0 <= data_i;
                end
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // XOR pipeline: stages_p-1 registers here, the buffer write is the last
    // ------------------------------------------------------------------
    logic                     exit_v;
    logic [block_width_p-1:0] exit_data;

    generate
        if (stages_p == 1) begin : g_direct
            assign exit_v    = issue;
            assign exit_data = xor_res;
        end else begin : g_pipe
            localparam int depth_lp = stages_p - 1;

            logic [depth_lp-1:0]      pv;
            logic [block_width_p-1:0] pd [depth_lp];

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    pv <= '0;
                    for (int i = 0; i < depth_lp; i++) begin
                        pd[i] <= '0;
                    end
                end else begin
                    pv[0] <= issue;
                    pd[0] <= xor_res;
                    for (int i = 1; i < depth_lp; i++) begin
                        pv[i] <= pv[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign exit_v    = pv[depth_lp-1];
            assign exit_data = pd[depth_lp-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    logic [block_width_p-1:0] mem [els_p];
    logic [ptr_w_lp-1:0]      wptr;
    logic [ptr_w_lp-1:0]      rptr;
    logic [cnt_w_lp-1:0]      bcnt;
    logic [beat_w_lp-1:0]     beat;
    logic                     pop;
    state_e                   state;

    assign pop = v_o & yumi_i & (beat == last_beat_lp);

    always_ff @(posedge clk_i) begin
        if (exit_v) begin
            mem[wptr] <= exit_data;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
            bcnt <= '0;
            occ  <= '0;
        end else begin
            if (exit_v) begin
                wptr <= (wptr == last_ptr_lp) ? '0 : wptr + ptr_w_lp'(1);
            end
            if (pop) begin
                rptr <= (rptr == last_ptr_lp) ? '0 : rptr + ptr_w_lp'(1);
            end
            unique case ({exit_v, pop})
                2'b10:   bcnt <= bcnt + one_lp;
                2'b01:   bcnt <= bcnt - one_lp;
                default: bcnt <= bcnt;
            endcase
            // Issue and last-beat release in one cycle cancel out
            unique case ({issue, pop})
                2'b10:   occ <= occ + one_lp;
                2'b01:   occ <= occ - one_lp;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output streamer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= e_empty;
            beat  <= '0;
        end else begin
            unique case (state)
                e_empty: begin
                    if (exit_v) begin
                        state <= e_stream;
                    end
                end
                e_stream: begin
                    if (yumi_i) begin
                        if (beat == last_beat_lp) begin
                            beat <= '0;
                            if ((bcnt == one_lp) && !exit_v) begin
                                state <= e_empty;
                            end
                        end else begin
                            beat <= beat + beat_w_lp'(1);
                        end
                    end
                end
                default: state <= e_empty;
            endcase
        end
    end

    logic [beats_lp-1:0][fill_width_p-1:0] head;

    assign head   = mem[rptr];
    assign v_o    = (state == e_stream);
    assign data_o = v_o ? head[beat] : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
            else $error("yumi_i asserted while v_o is low");
        end
    end

endmodule

// File: tb/tb_bp_be_accel_ws_xor_core.sv
// Directed scoreboard bench for bp_be_accel_ws_xor_core.
// Expected beats are queued at issue and popped as the DUT streams them.
module tb_bp_be_accel_ws_xor_core;

    localparam int BW    = 512;
    localparam int FW    = 128;
    localparam int BEATS = BW / FW;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op;
    logic [BW-1:0] din;
    logic          v_i;
    logic [FW-1:0] dout;
    logic          v_o;
    logic          yumi;
    logic          ready;
    logic          ovf;

    int n_assert = 0;
    int n_fail   = 0;

    logic [FW-1:0] exp_q [$];
    logic [BW-1:0] wm [2];

    always #5 clk = ~clk;

    bp_be_accel_ws_xor_core #(
        .block_width_p(BW),
        .fill_width_p (FW),
        .els_p        (2),
        .stages_p     (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .op_i      (op),
        .data_i    (din),
        .v_i       (v_i),
        .data_o    (dout),
        .v_o       (v_o),
        .yumi_i    (yumi),
        .ready_o   (ready),
        .overflow_o(ovf)
    );

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input logic [BW-1:0] b);
        for (int i = 0; i < BEATS; i++) begin
            exp_q.push_back(b[i*FW +: FW]);
        end
    endtask

    task automatic send(input logic [1:0] o, input logic [BW-1:0] d);
        op  = o;
        din = d;
        v_i = 1'b1;
        @(posedge clk);
        #1;
        v_i = 1'b0;
        op  = 2'b00;
        din = '0;
    endtask

    task automatic wtld(input int idx, input logic [BW-1:0] d);
        send({1'b1, idx[0]}, d);
        wm[idx] = d;
    endtask

    task automatic acld(input int idx, input logic [BW-1:0] d, input bit acc);
        if (acc) begin
            push_block(d ^ wm[idx]);
        end
        send({1'b0, idx[0]}, d);
    endtask

    task automatic drain(input int n, input string tag);
        int got;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            if (v_o) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra"}, dout, 'x);
                end else begin
                    chk(tag, dout, exp_q.pop_front());
                end
                yumi = 1'b1;
                got++;
            end
            @(posedge clk);
            #1;
            yumi = 1'b0;
        end
        chk({tag, "_count"}, FW'(got), FW'(n));
    endtask

    task automatic wait_v(input string tag);
        int c;
        c = 0;
        while (!v_o && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({tag, "_wait_v"}, FW'(v_o), FW'(1));
    endtask

    initial begin
        logic [BW-1:0] d;
        rst  = 1'b0;
        op   = 2'b00;
        din  = '0;
        v_i  = 1'b0;
        yumi = 1'b0;
        wm[0] = '0;
        wm[1] = '0;
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v_o", FW'(v_o), FW'(0));
        chk("rst_ready", FW'(ready), FW'(1));
        chk("rst_ovf", FW'(ovf), FW'(0));
        chk("rst_data", dout, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: ACLD0 with zero weight, latency check
        acld(0, {64{8'hA5}}, 1'b1);
        chk("t1_v_early", FW'(v_o), FW'(0));
        chk("t1_ready", FW'(ready), FW'(1));
        @(posedge clk);
        #1;
        chk("t1_v_first", FW'(v_o), FW'(1));
        drain(4, "t1_beat");

        // 2: weight load then use, other weight untouched
        wtld(1, {BW{1'b1}});
        acld(1, {64{8'h0F}}, 1'b1);
        acld(0, {64{8'h0F}}, 1'b1);
        drain(8, "t2_beat");

        // 3: beat order and stability while yumi held low
        d = {128'd3, 128'd2, 128'd1, 128'd0};
        acld(0, d, 1'b1);
        wait_v("t3");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_v", FW'(v_o), FW'(1));
            chk("t3_hold_data", dout, 128'd0);
            @(posedge clk);
            #1;
        end
        drain(4, "t3_beat");

        // 4: overflow with no consumer
        acld(0, {16{32'h1111_0001}}, 1'b1);
        acld(0, {16{32'h2222_0002}}, 1'b1);
        chk("t4_ready_full", FW'(ready), FW'(0));
        chk("t4_ovf_before", FW'(ovf), FW'(0));
        acld(0, {16{32'h3333_0003}}, 1'b0);
        chk("t4_ovf_set", FW'(ovf), FW'(1));
        chk("t4_ready_still", FW'(ready), FW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_ovf_sticky", FW'(ovf), FW'(1));
        drain(8, "t4_beat");
        repeat (3) @(posedge clk);
        #1;
        chk("t4_v_done", FW'(v_o), FW'(0));
        chk("t4_ready_back", FW'(ready), FW'(1));
        chk("t4_ovf_after", FW'(ovf), FW'(1));
        chk("t4_q_empty", FW'(exp_q.size()), FW'(0));

        // 5: weight snapshot at issue
        d = {8{64'h0123_4567_89AB_CDEF}};
        wtld(0, {BW{1'b1}});
        acld(0, d, 1'b1);
        wtld(0, '0);
        acld(0, d, 1'b1);
        drain(8, "t5_beat");

        // 6: async reset in the middle of a block
        wtld(0, {64{8'h55}});
        wtld(1, {64{8'h33}});
        acld(0, {16{32'hDEAD_BEEF}}, 1'b1);
        wait_v("t6");
        drain(2, "t6_pre");
        chk("t6_v_mid", FW'(v_o), FW'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_v", FW'(v_o), FW'(0));
        chk("t6_rst_data", dout, '0);
        chk("t6_rst_ready", FW'(ready), FW'(1));
        chk("t6_rst_ovf", FW'(ovf), FW'(0));
        exp_q.delete();
        wm[0] = '0;
        wm[1] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t6_quiet", FW'(v_o), FW'(0));
            @(posedge clk);
            #1;
        end
        d = {4{128'hCAFE_F00D_0000_1111_2222_3333_4444_5555}};
        acld(0, d, 1'b1);
        acld(1, d, 1'b1);
        drain(8, "t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
